pc_update: RTL and testbench
============================

# pc_update

Program-counter stage of the multi-cycle NPC core, directly downstream of `Branch_Cond`. It holds the architectural PC and issues one fetch request per instruction to the IFU. It accepts the execute-stage result (`PCAsrc`/`PCBsrc` from `Branch_Cond`, plus `rs1` and `imm`) and computes and commits the next PC. Misaligned targets and retired instructions are tracked here.

## Interface

Parameters:
- `XLEN`, 32: datapath width.
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pca_src`  in  1  `PCAsrc` from `Branch_Cond`; 1 = add `imm`, 0 = add 4.
- `pcb_src`  in  1  `PCBsrc` from `Branch_Cond`; 1 = base is `pc`, 0 = base is `rs1`.
- `rs1`  in  XLEN  source register 1 value.
- `imm`  in  XLEN  sign-extended immediate.
- `ex_valid`  in  1  execute result for the current `pc` is present.
- `ex_ready`  out  1  block accepts the execute result.
- `if_req_valid`  out  1  fetch request valid.
- `if_req_ready`  in  1  IFU accepts the request.
- `if_req_pc`  out  XLEN  fetch address; always equals `pc`.
- `pc`  out  XLEN  current architectural PC.
- `snpc`  out  XLEN  `pc + 4`, used as the link value for jal/jalr.
- `misalign`  out  1  sticky trap flag.
- `retired`  out  32  count of retired instructions.

## Operation

State machine with three states: FETCH, EXEC, TRAP.
- FETCH: `if_req_valid`=1 and `if_req_pc`=`pc`, both held stable until `if_req_ready`. On `if_req_ready`=1, go to EXEC.
- EXEC: `ex_ready`=1. When `ex_valid`=1, compute `dnpc` by `{pca_src,pcb_src}`:
  - 11 -> `pc+imm` (jal, taken branch).
  - 10 -> `(rs1+imm) & ~1` (jalr).
  - 01 -> `pc+4`.
  - 00 -> reserved; treated as `pc+4`.
- EXEC, `dnpc[1:0]` ≠ 0: `pc` is not updated, `misalign` is set to 1, `retired` is unchanged, go to TRAP.
- EXEC, otherwise: `pc` <= `dnpc`, `retired` increments by 1, go to FETCH.
- TRAP: all handshake outputs are 0. The block leaves TRAP only on `rst`.
- Arithmetic is modulo 2^XLEN; address wrap-around is legal, with no overflow detection. `retired` wraps from 2^32−1 to 0.
- `snpc` is combinational from `pc`.
- `ex_valid` outside EXEC and `if_req_ready` outside FETCH are ignored.

## Timing

- Reset (`rst`=1 at an edge), from any state including mid-handshake:
  - `pc`=`RESET_PC`, state=FETCH, `misalign`=0, `retired`=0.
  - While `rst`=1, `if_req_valid` and `ex_ready` are forced to 0.
- First fetch request: `if_req_valid`=1 in the first cycle after `rst` deasserts.
- Minimum 2 cycles per instruction: FETCH accepted in cycle n, result accepted in cycle n+1, next request in cycle n+2.
- The new `pc` is visible on `pc`, `if_req_pc` and `snpc` in the cycle after the EXEC handshake.
- `if_req_valid` is never retracted before `if_req_ready`, and `if_req_pc` does not change while the request is pending.
- `ex_ready` is a registered state decode; no combinational path from `ex_valid` to `ex_ready` or `if_req_valid`.
- `rst` and `ex_valid` asserted in the same cycle: reset wins and the commit is discarded.

## Structure

Shared package `npc_pkg`:
- state enum `pcu_state_t` {FETCH, EXEC, TRAP}.
- `RESET_PC` default.
- 2-bit next-PC select encodings `PCSEL_PC_IMM`, `PCSEL_RS1_IMM`, `PCSEL_PC_4`.

Sub-module: `next_pc_calc`, a combinational unit that takes `pc`, `rs1`, `imm` and the two selects, and produces `dnpc` and the misalign bit. It is reused by the difftest model.

## Test plan

- Reset, then hold `if_req_ready`=1 -> first request at 0x8000_0000; `retired`=0.
- `{1,1}` with `imm`=0x10 at `pc`=0x8000_0000 -> next `if_req_pc`=0x8000_0010; `retired`=1; `snpc` reads 0x8000_0014.
- `{1,0}` with `rs1`=0x8000_0101, `imm`=0x3 -> 0x8000_0104; the LSB clear is applied before the alignment check.
- `{1,1}` with `imm`=0x2 -> `misalign`=1, `pc` unchanged, `retired` unchanged, no further requests; `rst` then returns `pc` to 0x8000_0000 and clears `misalign`.
- `if_req_ready` held low for 5 cycles -> `if_req_valid` and `if_req_pc` stable all 5 cycles; `ex_valid` pulses during that time are ignored (pc/retired unchanged).
- `rst` asserted in the same cycle as the EXEC handshake -> commit discarded, `pc`=`RESET_PC`, `retired`=0.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: definitions shared by the NPC program-counter stage and its helpers.
//   pcu_state_t      : PC-stage state machine encoding (FETCH, EXEC, TRAP)
//   DEFAULT_RESET_PC : architectural PC loaded on reset
//   PCSEL_*          : {pca_src, pcb_src} encodings for next-PC selection
package npc_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } pcu_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // {pca_src, pcb_src}; 2'b00 is reserved and treated like PCSEL_PC_4.
  localparam logic [1:0] PCSEL_PC_IMM  = 2'b11;  // jal, taken branch
  localparam logic [1:0] PCSEL_RS1_IMM = 2'b10;  // jalr
  localparam logic [1:0] PCSEL_PC_4    = 2'b01;  // sequential

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC generator.
// Ports:
//   pc, rs1, imm      in  XLEN  current PC, source register 1, sign-extended immediate
//   pca_src, pcb_src  in  1     next-PC select from the branch-condition unit
//   dnpc              out XLEN  computed next PC
//   misalign          out 1     dnpc is not 4-byte aligned
module next_pc_calc
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            pca_src,
  input  logic            pcb_src,
  output logic [XLEN-1:0] dnpc,
  output logic            misalign
);

  always_comb begin
    dnpc = pc + XLEN'(4);
    case ({pca_src, pcb_src})
      PCSEL_PC_IMM:  dnpc = pc + imm;
      // jalr clears bit 0 before the alignment check, so an odd rs1+imm
      // can still produce an aligned target.
      PCSEL_RS1_IMM: dnpc = (rs1 + imm) & ~XLEN'(1);
      default:       dnpc = pc + XLEN'(4);
    endcase
  end

  assign misalign = |dnpc[1:0];

endmodule

// File: rtl/pc_update.sv
// pc_update: program-counter stage of the multi-cycle NPC core.
// Holds the architectural PC, issues one fetch request per instruction and
// commits the next PC when the execute result arrives. A misaligned target
// parks the block in TRAP until reset.
// Ports:
//   clk, rst                   core clock, synchronous active-high reset
//   pca_src, pcb_src, rs1, imm execute-stage next-PC inputs
//   ex_valid / ex_ready        execute-result handshake
//   if_req_valid / if_req_ready / if_req_pc   fetch request handshake
//   pc, snpc                   current PC and pc+4 link value
//   misalign                   sticky trap flag
//   retired                    retired-instruction counter (wraps)
module pc_update
  import npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(npc_pkg::DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pca_src,
  input  logic            pcb_src,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            ex_valid,
  output logic            ex_ready,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic            misalign,
  output logic [31:0]     retired
);

  pcu_state_t      state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            misalign_reg;
  logic [31:0]     retired_reg;
  logic            if_req_valid_reg;
  logic            ex_ready_reg;

  logic [XLEN-1:0] dnpc_next;
  logic            dnpc_misalign;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
    .pc       (pc_reg),
    .rs1      (rs1),
    .imm      (imm),
    .pca_src  (pca_src),
    .pcb_src  (pcb_src),
    .dnpc     (dnpc_next),
    .misalign (dnpc_misalign)
  );

  // Handshake flags are registered decodes of the next state. The request
  // flag is primed during reset so the first request appears in the very
  // first cycle after rst drops; the rst gate below keeps both at 0 while
  // reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= FETCH;
      pc_reg           <= RESET_PC;
      misalign_reg     <= 1'b0;
      retired_reg      <= 32'd0;
      if_req_valid_reg <= 1'b1;
      ex_ready_reg     <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (if_req_ready) begin
            state_reg        <= EXEC;
            if_req_valid_reg <= 1'b0;
            ex_ready_reg     <= 1'b1;
          end
        end
        EXEC: begin
          if (ex_valid) begin
            ex_ready_reg <= 1'b0;
            if (dnpc_misalign) begin
              // pc and retired stay untouched; the faulting pc remains visible.
              state_reg    <= TRAP;
              misalign_reg <= 1'b1;
            end else begin
              state_reg        <= FETCH;
              pc_reg           <= dnpc_next;
              retired_reg      <= retired_reg + 32'd1;
              if_req_valid_reg <= 1'b1;
            end
          end
        end
        TRAP: begin
          if_req_valid_reg <= 1'b0;
          ex_ready_reg     <= 1'b0;
        end
        default: begin
          state_reg        <= TRAP;
          if_req_valid_reg <= 1'b0;
          ex_ready_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign if_req_valid = if_req_valid_reg & ~rst;
  assign ex_ready     = ex_ready_reg & ~rst;
  assign if_req_pc    = pc_reg;
  assign pc           = pc_reg;
  assign snpc         = pc_reg + XLEN'(4);
  assign misalign     = misalign_reg;
  assign retired      = retired_reg;

endmodule

// File: tb/tb_pc_update.sv
// tb_pc_update: directed, table-driven bench for pc_update.
module tb_pc_update;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pca_src, pcb_src;
  logic [31:0] rs1, imm;
  logic        ex_valid;
  logic        ex_ready;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_pc;
  logic [31:0] pc, snpc;
  logic        misalign;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_update #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pca_src      (pca_src),
    .pcb_src      (pcb_src),
    .rs1          (rs1),
    .imm          (imm),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_pc    (if_req_pc),
    .pc           (pc),
    .snpc         (snpc),
    .misalign     (misalign),
    .retired      (retired)
  );

  typedef struct {
    logic        pca;
    logic        pcb;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; leaves the bench just after a falling edge.
  task automatic do_instr(input string name, input logic a, input logic b,
                          input logic [31:0] r1, input logic [31:0] im,
                          input logic [31:0] pc_before, input logic [31:0] exp_pc,
                          input logic [31:0] exp_ret, input logic exp_trap);
    int n = 0;
    while (!if_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " req_valid"}, 32'(if_req_valid), 32'd1);
    chk({name, " req_pc"}, if_req_pc, pc_before);
    if_req_ready = 1'b1;
    @(negedge clk);
    if_req_ready = 1'b0;
    chk({name, " ex_ready"}, 32'(ex_ready), 32'd1);
    pca_src = a; pcb_src = b; rs1 = r1; imm = im; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk({name, " pc"}, pc, exp_pc);
    chk({name, " snpc"}, snpc, exp_pc + 32'd4);
    chk({name, " retired"}, retired, exp_ret);
    chk({name, " misalign"}, 32'(misalign), 32'(exp_trap));
    chk({name, " next_req"}, 32'(if_req_valid), exp_trap ? 32'd0 : 32'd1);
    $display("instr %s sel=%b%b rs1=%h imm=%h -> pc=%h retired=%0d misalign=%b",
             name, a, b, r1, im, pc, retired, misalign);
  endtask

  initial begin
    rst = 1'b1; pca_src = 1'b0; pcb_src = 1'b0; rs1 = '0; imm = '0;
    ex_valid = 1'b0; if_req_ready = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0010, 32'h8000_0010, 32'd1};
    vecs[1] = '{1'b1, 1'b0, 32'h8000_0101, 32'h0000_0003, 32'h8000_0104, 32'd2};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0201, 32'h0000_0004, 32'h8000_0204, 32'd3};
    vecs[3] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5671, 32'h8000_0208, 32'd4};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h8000_020C, 32'd5};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFF4, 32'h8000_0200, 32'd6};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0004, 32'd7};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0000, 32'h7FFF_FFFC, 32'h8000_0000, 32'd8};

    // Reset state while rst is held.
    repeat (3) @(negedge clk);
    chk("rst req_valid", 32'(if_req_valid), 32'd0);
    chk("rst ex_ready", 32'(ex_ready), 32'd0);
    chk("rst pc", pc, RST_PC);
    chk("rst retired", retired, 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    rst = 1'b0;
    #1;
    chk("first req_valid", 32'(if_req_valid), 32'd1);
    chk("first req_pc", if_req_pc, RST_PC);
    @(negedge clk);

    // Table-driven instruction sequence.
    begin
      logic [31:0] cur_pc;
      cur_pc = RST_PC;
      for (int i = 0; i < 8; i++) begin
        do_instr($sformatf("v%0d", i), vecs[i].pca, vecs[i].pcb, vecs[i].rs1, vecs[i].imm,
                 cur_pc, vecs[i].exp_pc, vecs[i].exp_ret, 1'b0);
        cur_pc = vecs[i].exp_pc;
      end
    end

    // Fetch stall: request held, ex_valid pulses ignored.
    for (int c = 0; c < 5; c++) begin
      pca_src = 1'b1; pcb_src = 1'b1; imm = 32'h40; ex_valid = c[0];
      @(negedge clk);
      chk($sformatf("stall%0d req_valid", c), 32'(if_req_valid), 32'd1);
      chk($sformatf("stall%0d req_pc", c), if_req_pc, 32'h8000_0000);
      chk($sformatf("stall%0d retired", c), retired, 32'd8);
    end
    ex_valid = 1'b0;
    $display("stall 5 cycles pc=%h retired=%0d", pc, retired);

    // Misaligned jal target -> trap.
    do_instr("trap", 1'b1, 1'b1, 32'h0, 32'h2, 32'h8000_0000, 32'h8000_0000, 32'd8, 1'b1);
    if_req_ready = 1'b1; ex_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("trap%0d req_valid", c), 32'(if_req_valid), 32'd0);
      chk($sformatf("trap%0d ex_ready", c), 32'(ex_ready), 32'd0);
      chk($sformatf("trap%0d pc", c), pc, 32'h8000_0000);
      chk($sformatf("trap%0d misalign", c), 32'(misalign), 32'd1);
    end
    if_req_ready = 1'b0; ex_valid = 1'b0;

    // Reset out of TRAP.
    rst = 1'b1;
    @(negedge clk);
    chk("trap_rst misalign", 32'(misalign), 32'd0);
    chk("trap_rst retired", retired, 32'd0);
    chk("trap_rst req_valid", 32'(if_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("trap_rst req_pc", if_req_pc, RST_PC);
    @(negedge clk);
    $display("reset from trap pc=%h misalign=%b", pc, misalign);

    // Reset coinciding with the EXEC handshake.
    do_instr("pre", 1'b1, 1'b1, 32'h0, 32'h20, RST_PC, 32'h8000_0020, 32'd1, 1'b0);
    if_req_ready = 1'b1;
    @(negedge clk);
    if_req_ready = 1'b0;
    chk("rstx ex_ready", 32'(ex_ready), 32'd1);
    pca_src = 1'b1; pcb_src = 1'b1; imm = 32'h40; ex_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstx pc", pc, RST_PC);
    chk("rstx retired", retired, 32'd0);
    chk("rstx req_valid", 32'(if_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstx next req_valid", 32'(if_req_valid), 32'd1);
    $display("reset during exec pc=%h retired=%0d", pc, retired);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
